// File: rtl/keypad_seq_detector_pkg.sv
// Shared constants and helpers for the keypad code detector.
// Holds the hwclk rate, the unlock-flag state encoding and a constant log2 helper.
package keypad_pkg;

    localparam int   HWCLK_HZ = 12000000;

    localparam logic LOCKED   = 1'b0;
    localparam logic UNLOCKED = 1'b1;

    typedef enum logic {
        ST_LOCKED   = LOCKED,
        ST_UNLOCKED = UNLOCKED
    } unlock_state_t;

    // Ceiling log2; clog2(1) is 0, matching $clog2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/keypad_seq_detector_if.sv
// Keypad detector signal bundle: debounced presses, target code and relock in,
// match/unlock/error status out.
interface keypad_seq_detector_if
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int SEQ_LEN  = 4,
    parameter int KEY_W    = $clog2(NUM_KEYS),
    parameter int PROG_W   = clog2(SEQ_LEN + 1)
);
    logic [NUM_KEYS-1:0]      press;
    logic [SEQ_LEN*KEY_W-1:0] code;
    logic                     relock;
    logic                     match;
    logic                     unlocked;
    logic                     err;
    logic [PROG_W-1:0]        progress;
    logic [KEY_W-1:0]         last_key;

    modport master (
        output press, code, relock,
        input  match, unlocked, err, progress, last_key
    );

    modport slave (
        input  press, code, relock,
        output match, unlocked, err, progress, last_key
    );
endinterface

// File: rtl/keypad_seq_detector_key_encoder.sv
// One-hot press vector to key index, with single-key and chord classification.
module key_encoder
#(
    parameter int NUM_KEYS = 4,
    parameter int KEY_W    = $clog2(NUM_KEYS)
) (
    input  logic [NUM_KEYS-1:0] i_onehot,
    output logic [KEY_W-1:0]    o_index,
    output logic                o_valid,
    output logic                o_multi
);
    logic [NUM_KEYS-1:0] w_low_cleared;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign w_low_cleared = i_onehot & (i_onehot - NUM_KEYS'(1));
    assign o_multi       = |w_low_cleared;
    assign o_valid       = (|i_onehot) & ~o_multi;

    always_comb begin
        o_index = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (i_onehot[i]) begin
                o_index = KEY_W'(i);
            end
        end
    end
endmodule

// File: rtl/keypad_seq_detector.sv
// Overlap-aware programmable keypad code detector with inactivity timeout,
// chord rejection and latched or pulsed unlock indication.
module keypad_seq_detector
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int SEQ_LEN        = 4,
    parameter int KEY_W          = $clog2(NUM_KEYS),
    parameter int TIMEOUT_CYCLES = 2 * HWCLK_HZ,
    parameter bit LATCH_UNLOCK   = 1'b1
) (
    input  logic                 hwclk,
    input  logic                 rst,
    keypad_seq_detector_if.slave io_kp
);
    localparam int                PROG_W    = clog2(SEQ_LEN + 1);
    localparam int                CNT_W     = (TIMEOUT_CYCLES > 1) ? clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  IDLE_MAX  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [PROG_W-1:0] PROG_FULL = PROG_W'(SEQ_LEN);

    logic [KEY_W-1:0]                w_key_idx;
    logic                            w_key_valid;
    logic                            w_key_multi;
    logic                            w_key_ok;
    logic                            w_chord;
    logic                            w_code_eq;
    logic                            w_hit;
    logic                            w_timeout;
    logic [SEQ_LEN-1:0][KEY_W-1:0]   w_shift;
    logic [PROG_W-1:0]               w_prog_inc;

    logic [SEQ_LEN-1:0][KEY_W-1:0]   r_hist;
    logic [PROG_W-1:0]               r_prog;
    logic [CNT_W-1:0]                r_idle;
    logic [KEY_W-1:0]                r_last_key;
    logic                            r_match;
    logic                            r_err;
    unlock_state_t                   r_state;
    unlock_state_t                   w_state_nxt;

    key_encoder #(
        .NUM_KEYS (NUM_KEYS),
        .KEY_W    (KEY_W)
    ) u_key_encoder (
        .i_onehot (io_kp.press),
        .o_index  (w_key_idx),
        .o_valid  (w_key_valid),
        .o_multi  (w_key_multi)
    );

    // relock drops any press in the same cycle.
    assign w_key_ok   = w_key_valid & ~io_kp.relock;
    assign w_chord    = w_key_multi & ~io_kp.relock;
    assign w_prog_inc = (r_prog == PROG_FULL) ? r_prog : r_prog + PROG_W'(1);
    assign w_hit      = w_key_ok && (w_prog_inc == PROG_FULL) && w_code_eq;
    assign w_timeout  = (TIMEOUT_CYCLES > 0) && (r_prog != '0) && (r_idle == IDLE_MAX);

    // Slot 0 of the history is the newest key, so it lines up with the last code entry.
    always_comb begin
        w_shift    = '0;
        w_shift[0] = w_key_idx;
        for (int j = 1; j < SEQ_LEN; j++) begin
            w_shift[j] = r_hist[j-1];
        end
        w_code_eq = 1'b1;
        for (int j = 0; j < SEQ_LEN; j++) begin
            if (w_shift[j] != io_kp.code[(SEQ_LEN-1-j)*KEY_W +: KEY_W]) begin
                w_code_eq = 1'b0;
            end
        end
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_hist     <= '0;
            r_prog     <= '0;
            r_idle     <= '0;
            r_last_key <= '0;
            r_match    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_match <= w_hit;
            r_err   <= w_chord;
            if (io_kp.relock || w_chord) begin
                r_hist <= '0;
                r_prog <= '0;
                r_idle <= '0;
            end else if (w_key_ok) begin
                r_hist     <= w_shift;
                r_prog     <= w_prog_inc;
                r_last_key <= w_key_idx;
                r_idle     <= '0;
            end else if (w_timeout) begin
                r_hist <= '0;
                r_prog <= '0;
                r_idle <= '0;
            end else if ((TIMEOUT_CYCLES > 0) && (r_prog != '0)) begin
                r_idle <= r_idle + CNT_W'(1);
            end else begin
                r_idle <= '0;
            end
        end
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_state <= ST_LOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOCKED:   if (w_hit && LATCH_UNLOCK) w_state_nxt = ST_UNLOCKED;
            ST_UNLOCKED: if (io_kp.relock) w_state_nxt = ST_LOCKED;
            default:     w_state_nxt = ST_LOCKED;
        endcase
    end

    assign io_kp.match    = r_match;
    assign io_kp.err      = r_err;
    assign io_kp.progress = r_prog;
    assign io_kp.last_key = r_last_key;
    assign io_kp.unlocked = LATCH_UNLOCK ? (r_state == ST_UNLOCKED) : r_match;
endmodule

// File: tb/tb_keypad_seq_detector.sv
// Bench for keypad_seq_detector: two configurations driven by directed and random
// key streams, checked every cycle against a queue-style key history model.
module tb_keypad_seq_detector;
    logic hwclk = 1'b0;
    logic rst   = 1'b1;
    always #5 hwclk = ~hwclk;

    keypad_seq_detector_if #(.NUM_KEYS(2), .SEQ_LEN(4)) if0 ();
    keypad_seq_detector_if #(.NUM_KEYS(4), .SEQ_LEN(4)) if1 ();

    keypad_seq_detector #(
        .NUM_KEYS(2), .SEQ_LEN(4), .TIMEOUT_CYCLES(100), .LATCH_UNLOCK(1'b1)
    ) dut0 (
        .hwclk (hwclk),
        .rst   (rst),
        .io_kp (if0)
    );

    keypad_seq_detector #(
        .NUM_KEYS(4), .SEQ_LEN(4), .TIMEOUT_CYCLES(0), .LATCH_UNLOCK(1'b0)
    ) dut1 (
        .hwclk (hwclk),
        .rst   (rst),
        .io_kp (if1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-configuration model parameters.
    int c_nk    [2] = '{2, 4};
    int c_sl    [2] = '{4, 4};
    int c_to    [2] = '{100, 0};
    int c_latch [2] = '{1, 0};

    // Model state: entered keys oldest-first, count of held keys, etc.
    int m_code   [2][4];
    int m_hist   [2][8];
    int m_cnt    [2];
    int m_idle   [2];
    int m_last   [2];
    int m_unlock [2];
    int e_match  [2];
    int e_err    [2];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_code(input int d, input int k0, input int k1, input int k2, input int k3);
        m_code[d][0] = k0;
        m_code[d][1] = k1;
        m_code[d][2] = k2;
        m_code[d][3] = k3;
        if (d == 0) if0.code = {k3[0], k2[0], k1[0], k0[0]};
        else        if1.code = {k3[1:0], k2[1:0], k1[1:0], k0[1:0]};
    endtask

    task automatic model(input int d, input int p, input bit rl, input bit rs);
        int k;
        bit same;
        e_match[d] = 0;
        e_err[d]   = 0;
        if (rs) begin
            m_cnt[d] = 0; m_idle[d] = 0; m_last[d] = 0; m_unlock[d] = 0;
        end else if (rl) begin
            m_cnt[d] = 0; m_idle[d] = 0; m_unlock[d] = 0;
        end else if (p != 0) begin
            if ($countones(p) > 1) begin
                m_cnt[d] = 0; m_idle[d] = 0; e_err[d] = 1;
            end else begin
                k = 0;
                for (int i = 0; i < c_nk[d]; i++) if (p[i]) k = i;
                if (m_cnt[d] == c_sl[d]) begin
                    for (int i = 0; i < c_sl[d] - 1; i++) m_hist[d][i] = m_hist[d][i+1];
                    m_hist[d][c_sl[d]-1] = k;
                end else begin
                    m_hist[d][m_cnt[d]] = k;
                    m_cnt[d]++;
                end
                m_last[d] = k;
                m_idle[d] = 0;
                same = (m_cnt[d] == c_sl[d]);
                for (int i = 0; i < c_sl[d]; i++) if (m_hist[d][i] != m_code[d][i]) same = 0;
                if (same) begin
                    e_match[d] = 1;
                    if (c_latch[d] != 0) m_unlock[d] = 1;
                end
            end
        end else if (c_to[d] > 0 && m_cnt[d] > 0) begin
            m_idle[d]++;
            if (m_idle[d] == c_to[d]) begin
                m_cnt[d] = 0; m_idle[d] = 0;
            end
        end
    endtask

    task automatic compare(input int d);
        int exp_unl;
        exp_unl = (c_latch[d] != 0) ? m_unlock[d] : e_match[d];
        if (d == 0) begin
            chk("d0.match",    int'(if0.match),    e_match[0]);
            chk("d0.err",      int'(if0.err),      e_err[0]);
            chk("d0.unlocked", int'(if0.unlocked), exp_unl);
            chk("d0.progress", int'(if0.progress), m_cnt[0]);
            chk("d0.last_key", int'(if0.last_key), m_last[0]);
        end else begin
            chk("d1.match",    int'(if1.match),    e_match[1]);
            chk("d1.err",      int'(if1.err),      e_err[1]);
            chk("d1.unlocked", int'(if1.unlocked), exp_unl);
            chk("d1.progress", int'(if1.progress), m_cnt[1]);
            chk("d1.last_key", int'(if1.last_key), m_last[1]);
        end
    endtask

    task automatic step(input logic [1:0] p0, input logic r0, input logic [3:0] p1,
                        input logic r1, input logic rs);
        rst        = rs;
        if0.press  = p0;
        if0.relock = r0;
        if1.press  = p1;
        if1.relock = r1;
        model(0, int'(p0), r0, rs);
        model(1, int'(p1), r1, rs);
        @(negedge hwclk);
        compare(0);
        compare(1);
    endtask

    task automatic key0(input int k);
        step(2'(1 << k), 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic key1(input int k);
        step(2'd0, 1'b0, 4'(1 << k), 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0] p0;
        logic [3:0] p1;
        int r;
        if0.press = '0; if0.relock = 1'b0;
        if1.press = '0; if1.relock = 1'b0;
        set_code(0, 1, 0, 1, 1);
        set_code(1, 2, 3, 0, 1);
        @(negedge hwclk);
        step(2'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        step(2'd0, 1'b0, 4'd0, 1'b0, 1'b1);

        // Single match, then relock.
        key0(0); key0(1); key0(0); key0(1); key0(1);
        idle(2);
        step(2'd0, 1'b1, 4'd0, 1'b0, 1'b0);

        // Overlapping matches, then relock together with a press.
        key0(1); key0(0); key0(1); key0(1); key0(0); key0(1); key0(1);
        idle(1);
        step(2'b10, 1'b1, 4'd0, 1'b0, 1'b0);
        idle(1);

        // Inactivity timeout after three correct keys.
        key0(1); key0(0); key0(1);
        idle(100);
        key0(1);
        idle(1);

        // Reset in the middle of a sequence.
        step(2'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        key0(1); key0(0); key0(1);
        step(2'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        key0(1);
        idle(2);

        // Pulsed unlock and chord rejection on the four-key instance.
        key1(2); key1(3); key1(0); key1(1);
        idle(2);
        key1(2); key1(3);
        step(2'd0, 1'b0, 4'b0101, 1'b0, 1'b0);
        idle(1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            r  = $urandom_range(0, 99);
            p0 = (r < 40) ? 2'd0 : (r < 95) ? 2'(1 << $urandom_range(0, 1)) : 2'b11;
            r  = $urandom_range(0, 99);
            p1 = (r < 25) ? 4'd0 :
                 (r < 75) ? 4'(1 << m_code[1][$urandom_range(0, 3)]) :
                 (r < 92) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            step(p0, 1'($urandom_range(0, 79) == 0), p1, 1'($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 399) == 0));
            if (n % 600 == 300) begin
                key0(int'($urandom_range(0, 1)));
                idle(int'($urandom_range(98, 103)));
            end
            if (n % 700 == 0) begin
                set_code(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
